// File: rtl/apb_arb_pkg.sv
// Shared types and helpers for the APB request arbiter.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_e;

    localparam int DEFAULT_TIMEOUT = 256;

    // LSB position of requester idx inside a packed per-requester bus.
    function automatic int slice_lsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   grant_idx,
    output logic            any_req
);

    logic [PW-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_req   = 1'b0;
        cand      = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = PW'((int'(ptr) + i) % NREQ);
            if (!any_req && req[cand]) begin
                any_req     = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB bridge master port among NREQ requesters,
// one outstanding transfer at a time with a per-transfer watchdog.
module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int COMP       = 4,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic                       PCLK,
    input  logic                       PRESETn,
    input  logic [NREQ-1:0]            REQ_VALID,
    input  logic [NREQ-1:0]            REQ_WRITE,
    input  logic [NREQ*COMP-1:0]       REQ_SEL,
    input  logic [NREQ*ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic [NREQ*DATA_WIDTH-1:0] REQ_WDATA,
    output logic [NREQ-1:0]            REQ_DONE,
    output logic [NREQ-1:0]            REQ_ERR,
    output logic [DATA_WIDTH-1:0]      REQ_RDATA,
    output logic [NREQ-1:0]            GRANT,
    output logic                       MTRANS,
    output logic                       MWRITE,
    output logic [COMP-1:0]            MSELx,
    output logic [ADDR_WIDTH-1:0]      MADDR,
    output logic [DATA_WIDTH-1:0]      MWDATA,
    input  logic [DATA_WIDTH-1:0]      MRDATA,
    input  logic                       XFER_DONE
);

    localparam int PW = $clog2(NREQ);
    localparam int TW = $clog2(TIMEOUT + 1);

    arb_state_e      state_q, state_d;
    logic [PW-1:0]   ptr_q;
    logic [PW-1:0]   gidx_q;
    logic [TW-1:0]   timer_q;
    logic [NREQ-1:0] arb_grant;
    logic [PW-1:0]   arb_idx;
    logic            arb_any;
    logic            timeout_hit;

    rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
        .req       (REQ_VALID),
        .ptr       (ptr_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any_req   (arb_any)
    );

    assign timeout_hit = (timer_q == TW'(TIMEOUT - 1));

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (arb_any) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (XFER_DONE || timeout_hit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered one step ahead of the state they belong to, so the
    // bridge sees MTRANS the cycle after ISSUE and REQ_DONE lands in DONE.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            ptr_q     <= '0;
            gidx_q    <= '0;
            timer_q   <= '0;
            GRANT     <= '0;
            MTRANS    <= 1'b0;
            MWRITE    <= 1'b0;
            MSELx     <= '0;
            MADDR     <= '0;
            MWDATA    <= '0;
            REQ_DONE  <= '0;
            REQ_ERR   <= '0;
            REQ_RDATA <= '0;
        end else begin
            MTRANS    <= (state_q == ISSUE);
            REQ_DONE  <= '0;
            REQ_ERR   <= '0;
            REQ_RDATA <= '0;
            case (state_q)
                IDLE: begin
                    if (arb_any) begin
                        GRANT  <= arb_grant;
                        gidx_q <= arb_idx;
                        MWRITE <= REQ_WRITE[arb_idx];
                        MSELx  <= REQ_SEL[slice_lsb(int'(arb_idx), COMP) +: COMP];
                        MADDR  <= REQ_ADDR[slice_lsb(int'(arb_idx), ADDR_WIDTH) +: ADDR_WIDTH];
                        MWDATA <= REQ_WDATA[slice_lsb(int'(arb_idx), DATA_WIDTH) +: DATA_WIDTH];
                    end
                end
                ISSUE: timer_q <= '0;
                WAIT: begin
                    if (timer_q != TW'(TIMEOUT)) timer_q <= timer_q + TW'(1);
                    // A completion in the expiry cycle still counts as a clean finish.
                    if (XFER_DONE) begin
                        REQ_DONE  <= GRANT;
                        REQ_RDATA <= MWRITE ? '0 : MRDATA;
                    end else if (timeout_hit) begin
                        REQ_DONE <= GRANT;
                        REQ_ERR  <= GRANT;
                    end
                end
                DONE: begin
                    GRANT <= '0;
                    ptr_q <= (gidx_q == PW'(NREQ - 1)) ? '0 : gidx_q + PW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Self-checking bench: directed scenarios then randomized traffic against a
// transaction-level round-robin model.
module tb_apb_req_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;

    logic          PCLK = 1'b0;
    logic          PRESETn;
    logic [3:0]    REQ_VALID, REQ_WRITE;
    logic [15:0]   REQ_SEL;
    logic [127:0]  REQ_ADDR, REQ_WDATA;
    logic [3:0]    REQ_DONE, REQ_ERR, GRANT;
    logic [31:0]   REQ_RDATA;
    logic          MTRANS, MWRITE;
    logic [3:0]    MSELx;
    logic [31:0]   MADDR, MWDATA, MRDATA;
    logic          XFER_DONE;

    logic [31:0] pAddr[N];
    logic [31:0] pWdata[N];
    logic [3:0]  pSel[N];
    logic        pWrite[N];
    logic        pValid[N];

    int vectors = 0;
    int miscompares = 0;
    int mPtr = 0;
    int mode = 1;

    apb_req_arbiter #(
        .NREQ(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .COMP(4), .TIMEOUT(TO)
    ) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .REQ_VALID(REQ_VALID), .REQ_WRITE(REQ_WRITE), .REQ_SEL(REQ_SEL),
        .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
        .REQ_DONE(REQ_DONE), .REQ_ERR(REQ_ERR), .REQ_RDATA(REQ_RDATA),
        .GRANT(GRANT), .MTRANS(MTRANS), .MWRITE(MWRITE), .MSELx(MSELx),
        .MADDR(MADDR), .MWDATA(MWDATA), .MRDATA(MRDATA), .XFER_DONE(XFER_DONE)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] simulation did not finish");
    end

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic applyStimulus();
        for (int k = 0; k < N; k++) begin
            REQ_VALID[k]          = pValid[k];
            REQ_WRITE[k]          = pWrite[k];
            REQ_SEL[k*4 +: 4]     = pSel[k];
            REQ_ADDR[k*32 +: 32]  = pAddr[k];
            REQ_WDATA[k*32 +: 32] = pWdata[k];
        end
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Round-robin rule: first valid requester at or after the pointer, wrapping.
    function automatic int pickNext(input logic [3:0] v, input int ptr);
        int idx;
        for (int k = 0; k < N; k++) begin
            idx = (ptr + k) % N;
            if (v[idx[1:0]]) return idx;
        end
        return -1;
    endfunction

    task automatic randPayload(input int k);
        pWrite[k] = 1'($urandom_range(0, 1));
        pSel[k]   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                                : 4'(1 << $urandom_range(0, 3));
        pAddr[k]  = $urandom;
        pWdata[k] = $urandom;
    endtask

    task automatic setReq(input int k, input logic wr, input logic [3:0] sel,
                          input logic [31:0] addr, input logic [31:0] wdata);
        pValid[k] = 1'b1;
        pWrite[k] = wr;
        pSel[k]   = sel;
        pAddr[k]  = addr;
        pWdata[k] = wdata;
    endtask

    task automatic ensureOne();
        int k;
        if (!(pValid[0] || pValid[1] || pValid[2] || pValid[3])) begin
            k = int'($urandom_range(0, N - 1));
            pValid[k] = 1'b1;
            randPayload(k);
        end
    endtask

    task automatic clearAll();
        for (int k = 0; k < N; k++) pValid[k] = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_grant"}, 64'(GRANT), 64'd0);
        checkOutput({tag, "_mtrans"}, 64'(MTRANS), 64'd0);
        checkOutput({tag, "_mwrite"}, 64'(MWRITE), 64'd0);
        checkOutput({tag, "_msel"}, 64'(MSELx), 64'd0);
        checkOutput({tag, "_maddr"}, 64'(MADDR), 64'd0);
        checkOutput({tag, "_mwdata"}, 64'(MWDATA), 64'd0);
        checkOutput({tag, "_done"}, 64'(REQ_DONE), 64'd0);
        checkOutput({tag, "_err"}, 64'(REQ_ERR), 64'd0);
        checkOutput({tag, "_rdata"}, 64'(REQ_RDATA), 64'd0);
    endtask

    // One complete transfer, entered in an IDLE cycle with requests applied;
    // d < 0 means the bridge never answers, otherwise XFER_DONE d cycles after MTRANS.
    task automatic runOne(input int d, input logic [31:0] rd, input bit stray);
        int g;
        logic [3:0] gv;
        logic [31:0] eAddr, eWdata;
        logic [3:0] eSel;
        logic eWrite;
        g = pickNext(REQ_VALID, mPtr);
        if (g < 0) begin
            $display("[TB] runOne called with no valid requester");
            return;
        end
        gv = 4'(1 << g);
        eAddr = pAddr[g]; eWdata = pWdata[g]; eSel = pSel[g]; eWrite = pWrite[g];

        tick();
        checkOutput("grant_issue", 64'(GRANT), 64'(gv));
        checkOutput("maddr", 64'(MADDR), 64'(eAddr));
        checkOutput("mwdata", 64'(MWDATA), 64'(eWdata));
        checkOutput("msel", 64'(MSELx), 64'(eSel));
        checkOutput("mwrite", 64'(MWRITE), 64'(eWrite));
        checkOutput("mtrans_pre", 64'(MTRANS), 64'd0);
        if (stray) XFER_DONE = 1'b1;

        tick();
        XFER_DONE = 1'b0;
        MRDATA = $urandom;
        checkOutput("mtrans_pulse", 64'(MTRANS), 64'd1);
        checkOutput("grant_wait", 64'(GRANT), 64'(gv));
        if (mode == 0 && $urandom_range(0, 3) == 0) begin
            pValid[g] = 1'b0;
            applyStimulus();
        end

        if (d >= 0) begin
            for (int i = 0; i < d; i++) begin
                tick();
                checkOutput("mtrans_low", 64'(MTRANS), 64'd0);
                checkOutput("done_early", 64'(REQ_DONE), 64'd0);
            end
            XFER_DONE = 1'b1;
            MRDATA = rd;
            tick();
            XFER_DONE = 1'b0;
            MRDATA = $urandom;
            checkOutput("req_done", 64'(REQ_DONE), 64'(gv));
            checkOutput("req_err", 64'(REQ_ERR), 64'd0);
            checkOutput("req_rdata", 64'(REQ_RDATA), eWrite ? 64'd0 : 64'(rd));
        end else begin
            for (int i = 1; i < TO; i++) begin
                tick();
                MRDATA = $urandom;
                checkOutput("done_before_to", 64'(REQ_DONE), 64'd0);
            end
            tick();
            checkOutput("to_done", 64'(REQ_DONE), 64'(gv));
            checkOutput("to_err", 64'(REQ_ERR), 64'(gv));
            checkOutput("to_rdata", 64'(REQ_RDATA), 64'd0);
            XFER_DONE = 1'b1;
        end
        checkOutput("maddr_held", 64'(MADDR), 64'(eAddr));
        checkOutput("grant_done", 64'(GRANT), 64'(gv));
        mPtr = (g + 1) % N;

        if (mode == 0) begin
            pValid[g] = 1'($urandom_range(0, 1));
            if (pValid[g]) randPayload(g);
            for (int k = 0; k < N; k++)
                if (k != g && !pValid[k] && $urandom_range(0, 1) == 1) begin
                    pValid[k] = 1'b1;
                    randPayload(k);
                end
            ensureOne();
        end else if (mode == 1) begin
            pValid[g] = 1'b0;
        end
        applyStimulus();

        tick();
        XFER_DONE = 1'b0;
        checkOutput("grant_idle", 64'(GRANT), 64'd0);
        checkOutput("done_idle", 64'(REQ_DONE), 64'd0);
        checkOutput("mtrans_idle", 64'(MTRANS), 64'd0);
    endtask

    initial begin
        PRESETn = 1'b0;
        XFER_DONE = 1'b0;
        MRDATA = '0;
        for (int k = 0; k < N; k++) begin
            pValid[k] = 1'b0; pWrite[k] = 1'b0; pSel[k] = '0; pAddr[k] = '0; pWdata[k] = '0;
        end
        applyStimulus();
        tick();
        tick();
        checkAllZero("reset");
        PRESETn = 1'b1;

        // Single write from requester 0.
        setReq(0, 1'b1, 4'b0001, 32'h10, 32'hA5);
        applyStimulus();
        runOne(3, 32'h0, 1'b0);

        // Read from requester 2, then a write must return zero read data.
        clearAll();
        setReq(2, 1'b0, 4'b0100, 32'h24, 32'h0);
        applyStimulus();
        runOne(1, 32'hDEADBEEF, 1'b0);
        setReq(3, 1'b1, 4'b1000, 32'h30, 32'h5555AAAA);
        applyStimulus();
        runOne(0, 32'h12345678, 1'b0);

        // All requesters held: rotation 0,1,2,3,0.
        mode = 2;
        for (int k = 0; k < N; k++) setReq(k, k[0], 4'(1 << k), 32'h100 + 32'(k), 32'hC0 + 32'(k));
        applyStimulus();
        for (int t = 0; t < 5; t++) runOne(2, 32'hFACE0000 + 32'(t), 1'b0);

        // Timeout on requester 1 with requester 2 waiting, late XFER_DONE ignored.
        mode = 1;
        clearAll();
        setReq(1, 1'b1, 4'b0010, 32'h44, 32'h11);
        setReq(2, 1'b0, 4'b0100, 32'h48, 32'h0);
        applyStimulus();
        runOne(-1, 32'h0, 1'b0);
        runOne(4, 32'hBEEF0002, 1'b1);

        // Completion coincident with watchdog expiry.
        clearAll();
        setReq(0, 1'b0, 4'b0001, 32'h50, 32'h0);
        applyStimulus();
        runOne(TO - 1, 32'h0BADF00D, 1'b0);

        // Asynchronous reset in the middle of a transfer from requester 3.
        clearAll();
        setReq(3, 1'b1, 4'b1000, 32'h60, 32'h77);
        applyStimulus();
        tick();
        checkOutput("rst_grant3", 64'(GRANT), 64'h8);
        tick();
        tick();
        PRESETn = 1'b0;
        #2;
        checkAllZero("async_rst");
        setReq(0, 1'b1, 4'b0001, 32'h70, 32'h99);
        applyStimulus();
        tick();
        tick();
        checkOutput("rst_no_done", 64'(REQ_DONE), 64'd0);
        PRESETn = 1'b1;
        mPtr = 0;
        runOne(1, 32'h0, 1'b0);
        runOne(2, 32'h0, 1'b0);

        // Randomized traffic.
        mode = 0;
        ensureOne();
        applyStimulus();
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 4) == 0) runOne(-1, 32'h0, 1'($urandom_range(0, 1)));
            else runOne(int'($urandom_range(0, TO - 1)), $urandom, ($urandom_range(0, 3) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
